// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU MEM-stage, host requester and DMemory_IO signals around the arbiter.
// master: the surroundings (CPU, host, memory); slave: the arbiter itself.
// Pure wiring, no state.
interface dmem_port_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   // CPU MEM stage
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_write;
   logic              cpu_read;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   // host / debug requester
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic [DATA_W-1:0] host_rdata;
   logic              host_rvalid;
   logic              host_err;
   // data memory port
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_write;
   logic              mem_read;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output cpu_addr, cpu_wdata, cpu_write, cpu_read,
      input  cpu_rdata, cpu_stall,
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rdata, host_rvalid, host_err,
      input  mem_addr, mem_wdata, mem_write, mem_read,
      output mem_rdata
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_write, cpu_read,
      output cpu_rdata, cpu_stall,
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rdata, host_rvalid, host_err,
      output mem_addr, mem_wdata, mem_write, mem_read,
      input  mem_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the CPU MEM stage (priority) and a host requester.
// Latency: grant is combinational; host read data/rvalid one cycle after the grant; host waits at most MAX_WAIT+2 cycles.
// Backpressure: host holds host_req until host_gnt; after MAX_WAIT+1 blocked cycles the CPU is stalled for one cycle.
// Optional: define DMEM_ARB_IO_PROTECT_EN to block host writes at or above IO_BASE (reported on host_err).
module dmem_port_arbiter #(
   parameter int              DATA_W   = 16,
   parameter int              ADDR_W   = 16,
   parameter int              MAX_WAIT = 4,
   parameter int              WAIT_W   = 3,
   parameter logic [ADDR_W-1:0] IO_BASE = 16'hFFF0
) (
   input  logic               clock_i,
   input  logic               reset_i,
   dmem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              host_gnt;
   logic              cpu_stall;
   logic              cpu_acc;
   logic              io_block;
   logic              host_rvalid_q;
   logic [DATA_W-1:0] host_rdata_q;

   assign cpu_acc = bus.cpu_read | bus.cpu_write;

`ifdef DMEM_ARB_IO_PROTECT_EN
   logic host_err_q;

   assign io_block = bus.host_we & (bus.host_addr >= IO_BASE);

   // Flag a swallowed IO write to the host one cycle after its grant
   always_ff @(posedge clock_i) begin
      if (reset_i) host_err_q <= 1'b0;
      else         host_err_q <= host_gnt & io_block;
   end

   assign bus.host_err = host_err_q;
`else
   logic unused_io_base;

   assign io_block       = 1'b0;
   assign unused_io_base = ^IO_BASE;
   assign bus.host_err   = 1'b0;
`endif

   // Arbitration state and blocked-cycle counter
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next state, host grant and forced CPU stall; reset masks both outputs
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      host_gnt   = 1'b0;
      cpu_stall  = 1'b0;
      if (!reset_i) begin
         case (state_q)
            S_IDLE: begin
               if (bus.host_req && !cpu_acc) begin
                  host_gnt = 1'b1;
               end else if (bus.host_req) begin
                  state_d    = S_WAIT;
                  wait_cnt_d = WAIT_W'(1);
               end
            end
            S_WAIT: begin
               if (!bus.host_req) begin
                  // host withdrew its request; nothing to serve
                  state_d    = S_IDLE;
                  wait_cnt_d = '0;
               end else if (!cpu_acc) begin
                  host_gnt   = 1'b1;
                  state_d    = S_IDLE;
                  wait_cnt_d = '0;
               end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
                  state_d = S_FORCE;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
            S_FORCE: begin
               // one stolen cycle; always back to IDLE so stalls never repeat back to back
               host_gnt   = 1'b1;
               cpu_stall  = 1'b1;
               state_d    = S_IDLE;
               wait_cnt_d = '0;
            end
            default: begin
               state_d    = S_IDLE;
               wait_cnt_d = '0;
            end
         endcase
      end
   end

   // Memory port mux: the granted host owns the port, otherwise the CPU drives it
   always_comb begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_write = bus.cpu_write;
      bus.mem_read  = bus.cpu_read;
      if (host_gnt) begin
         bus.mem_addr  = bus.host_addr;
         bus.mem_wdata = bus.host_wdata;
         bus.mem_write = bus.host_we & ~io_block;
         bus.mem_read  = ~bus.host_we;
      end
   end

   // Capture host read data on the edge that completes a granted read
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
      end else begin
         host_rvalid_q <= host_gnt & ~bus.host_we;
         if (host_gnt && !bus.host_we) host_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.host_gnt    = host_gnt;
   assign bus.cpu_stall   = cpu_stall;
   assign bus.cpu_rdata   = bus.mem_rdata;
   assign bus.host_rvalid = host_rvalid_q;
   assign bus.host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios with literal expectations, then randomized
// CPU/host traffic checked every cycle against a behavioural model of the arbitration rules.
module tb_dmem_port_arbiter;

   localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_IO_PROTECT_EN
   localparam bit IO_PROT = 1'b1;
`else
   localparam bit IO_PROT = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dmem_port_arbiter_if #(.DATA_W(16), .ADDR_W(16)) ifc ();

   dmem_port_arbiter #(
      .DATA_W(16), .ADDR_W(16), .MAX_WAIT(MAX_WAIT), .WAIT_W(3), .IO_BASE(16'hFFF0)
   ) dut (
      .clock_i(clock),
      .reset_i(reset),
      .bus    (ifc.slave)
   );

   // memory behind the port: 256 words, aliased by the low address byte, async read
   logic [15:0] mem [256];
   assign ifc.mem_rdata = mem[ifc.mem_addr[7:0]];
   always @(posedge clock) if (ifc.mem_write) mem[ifc.mem_addr[7:0]] <= ifc.mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // blocked = number of consecutive cycles the current host request has been refused.
   // After MAX_WAIT+1 refusals the host must be served with a CPU stall.
   int          blocked    = 0;
   logic        mdl_gnt    = 1'b0;
   logic        exp_rvalid = 1'b0;
   logic [15:0] exp_rdata  = 16'h0;
   logic        exp_err    = 1'b0;

   always @(negedge clock) begin : model
      logic        e_gnt, e_stall, e_wr, e_rd, io_hit;
      logic [15:0] e_addr, e_wdata;
      logic        cpu_acc;
      cpu_acc = ifc.cpu_read | ifc.cpu_write;
      io_hit  = IO_PROT && ifc.host_we && (ifc.host_addr >= 16'hFFF0);
      e_gnt   = 1'b0;
      e_stall = 1'b0;
      if (!reset) begin
         if (blocked == MAX_WAIT + 1) begin
            e_gnt   = 1'b1;
            e_stall = 1'b1;
         end else if (ifc.host_req && !cpu_acc) begin
            e_gnt = 1'b1;
         end
      end
      if (e_gnt) begin
         e_addr  = ifc.host_addr;
         e_wdata = ifc.host_wdata;
         e_wr    = ifc.host_we && !io_hit;
         e_rd    = !ifc.host_we;
      end else begin
         e_addr  = ifc.cpu_addr;
         e_wdata = ifc.cpu_wdata;
         e_wr    = ifc.cpu_write;
         e_rd    = ifc.cpu_read;
      end
      chk("m_gnt",    32'(ifc.host_gnt),    32'(e_gnt));
      chk("m_stall",  32'(ifc.cpu_stall),   32'(e_stall));
      chk("m_maddr",  32'(ifc.mem_addr),    32'(e_addr));
      chk("m_mwdata", 32'(ifc.mem_wdata),   32'(e_wdata));
      chk("m_mwrite", 32'(ifc.mem_write),   32'(e_wr));
      chk("m_mread",  32'(ifc.mem_read),    32'(e_rd));
      chk("m_crdata", 32'(ifc.cpu_rdata),   32'(mem[e_addr[7:0]]));
      chk("m_rvalid", 32'(ifc.host_rvalid), 32'(exp_rvalid));
      chk("m_rdata",  32'(ifc.host_rdata),  32'(exp_rdata));
      chk("m_err",    32'(ifc.host_err),    32'(exp_err));
      if (reset) begin
         blocked    = 0;
         exp_rvalid = 1'b0;
         exp_rdata  = 16'h0;
         exp_err    = 1'b0;
      end else begin
         exp_rvalid = e_gnt && !ifc.host_we;
         if (exp_rvalid) exp_rdata = mem[ifc.host_addr[7:0]];
         exp_err = e_gnt && io_hit;
         if (e_gnt || !ifc.host_req) blocked = 0;
         else                        blocked = blocked + 1;
      end
      mdl_gnt = e_gnt;
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // waits (bounded) for a grant; returns its cycle index and the outputs seen in that cycle
   task automatic wait_gnt(output int idx, output logic stall, output logic wr, output logic [15:0] addr);
      idx   = -1;
      stall = 1'b0;
      wr    = 1'b0;
      addr  = 16'h0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (ifc.host_gnt) begin
            idx   = i;
            stall = ifc.cpu_stall;
            wr    = ifc.mem_write;
            addr  = ifc.mem_addr;
            break;
         end
         cyc();
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          idx;
      logic        st, wr;
      logic [15:0] ad;
      int          busy_pct;

      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      mem[8'h10] = 16'h1234;

      ifc.cpu_addr   = 16'h0055;
      ifc.cpu_wdata  = 16'h0;
      ifc.cpu_write  = 1'b0;
      ifc.cpu_read   = 1'b1;
      ifc.host_req   = 1'b1;
      ifc.host_we    = 1'b0;
      ifc.host_addr  = 16'h0010;
      ifc.host_wdata = 16'h0;
      reset          = 1'b1;

      // reset held two cycles with a pending host request
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         chk("rst_gnt",    32'(ifc.host_gnt),    32'h0);
         chk("rst_stall",  32'(ifc.cpu_stall),   32'h0);
         chk("rst_rvalid", 32'(ifc.host_rvalid), 32'h0);
         chk("rst_maddr",  32'(ifc.mem_addr),    32'h0055);
         cyc();
      end

      // CPU idle, host read of 0x0010
      reset        = 1'b0;
      ifc.cpu_read = 1'b0;
      @(negedge clock);
      chk("rd_gnt", 32'(ifc.host_gnt), 32'h1);
      cyc();
      ifc.host_req = 1'b0;
      @(negedge clock);
      chk("rd_rvalid", 32'(ifc.host_rvalid), 32'h1);
      chk("rd_rdata",  32'(ifc.host_rdata),  32'h1234);
      cyc();

      // CPU reads every cycle, host write forced in after MAX_WAIT WAIT cycles
      ifc.cpu_read   = 1'b1;
      ifc.cpu_addr   = 16'h0030;
      ifc.host_req   = 1'b1;
      ifc.host_we    = 1'b1;
      ifc.host_addr  = 16'h0020;
      ifc.host_wdata = 16'hBEEF;
      wait_gnt(idx, st, wr, ad);
      chk("force_idx",   32'(idx), 32'd5);
      chk("force_stall", 32'(st),  32'h1);
      chk("force_wr",    32'(wr),  32'h1);
      chk("force_addr",  32'(ad),  32'h0020);
      cyc();
      ifc.host_req = 1'b0;
      @(negedge clock);
      chk("post_force_stall", 32'(ifc.cpu_stall), 32'h0);
      chk("mem_beef",         32'(mem[8'h20]),    32'hBEEF);
      cyc();

      // CPU access drops in the second blocked cycle: grant without stall
      ifc.host_req  = 1'b1;
      ifc.host_we   = 1'b0;
      ifc.host_addr = 16'h0040;
      @(negedge clock);
      chk("drop_c0_gnt", 32'(ifc.host_gnt), 32'h0);
      cyc();
      @(negedge clock);
      chk("drop_c1_gnt", 32'(ifc.host_gnt), 32'h0);
      cyc();
      ifc.cpu_read = 1'b0;
      @(negedge clock);
      chk("drop_c2_gnt",   32'(ifc.host_gnt),  32'h1);
      chk("drop_c2_stall", 32'(ifc.cpu_stall), 32'h0);
      cyc();
      // counter restarted: the next blocked request waits the full span again
      ifc.cpu_read  = 1'b1;
      ifc.host_addr = 16'h0041;
      wait_gnt(idx, st, wr, ad);
      chk("restart_idx",   32'(idx), 32'd5);
      chk("restart_stall", 32'(st),  32'h1);
      cyc();
      ifc.host_req = 1'b0;
      ifc.cpu_read = 1'b0;
      cyc();

      // host write to the first IO address with the CPU idle
      ifc.host_req   = 1'b1;
      ifc.host_we    = 1'b1;
      ifc.host_addr  = 16'hFFF0;
      ifc.host_wdata = 16'hCAFE;
      @(negedge clock);
      chk("io_gnt",   32'(ifc.host_gnt),  32'h1);
      chk("io_write", 32'(ifc.mem_write), IO_PROT ? 32'h0 : 32'h1);
      cyc();
      ifc.host_req = 1'b0;
      @(negedge clock);
      chk("io_err", 32'(ifc.host_err), IO_PROT ? 32'h1 : 32'h0);
      cyc();
      @(negedge clock);
      chk("io_err_pulse", 32'(ifc.host_err), 32'h0);
      cyc();

      // reset lands on the FORCE cycle
      ifc.cpu_read  = 1'b1;
      ifc.host_req  = 1'b1;
      ifc.host_we   = 1'b0;
      ifc.host_addr = 16'h0050;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         cyc();
      end
      reset = 1'b1;
      @(negedge clock);
      chk("rf_gnt",   32'(ifc.host_gnt),  32'h0);
      chk("rf_stall", 32'(ifc.cpu_stall), 32'h0);
      cyc();
      reset = 1'b0;
      wait_gnt(idx, st, wr, ad);
      chk("rf_restart_idx", 32'(idx), 32'd5);
      cyc();
      ifc.host_req = 1'b0;
      ifc.cpu_read = 1'b0;

      // randomized traffic, three CPU load levels
      for (int n = 0; n < 3000; n++) begin
         cyc();
         busy_pct = (n < 1000) ? 30 : (n < 2000) ? 85 : 100;
         reset    = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 99) < busy_pct) begin
            ifc.cpu_write = $urandom_range(0, 1) == 1;
            ifc.cpu_read  = !ifc.cpu_write;
         end else begin
            ifc.cpu_write = 1'b0;
            ifc.cpu_read  = 1'b0;
         end
         ifc.cpu_addr  = 16'($urandom);
         ifc.cpu_wdata = 16'($urandom);
         if (ifc.host_req && mdl_gnt) ifc.host_req = 1'b0;
         if (!ifc.host_req) begin
            if ($urandom_range(0, 99) < 40) begin
               ifc.host_req   = 1'b1;
               ifc.host_we    = $urandom_range(0, 1) == 1;
               ifc.host_addr  = ($urandom_range(0, 9) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                                            : 16'($urandom_range(0, 255));
               ifc.host_wdata = 16'($urandom);
            end
         end else if (blocked <= MAX_WAIT && $urandom_range(0, 99) < 5) begin
            ifc.host_req = 1'b0;
         end
      end
      cyc();
      reset = 1'b0;
      @(negedge clock);
      @(posedge clock);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
